// File: rtl/bcd_timer_n_if.sv
// Control and data bundle for the N-digit BCD timer.
// The controller side drives buttons and preload data; the timer side returns count, lap, state and done.
interface bcd_timer_n_if #(
    parameter int NDIG = 3
);
    logic              start;
    logic              stop;
    logic              clear;
    logic              dir;
    logic              load_en;
    logic [4*NDIG-1:0] load_val;
    logic              lap;
    logic [4*NDIG-1:0] count;
    logic [4*NDIG-1:0] lap_val;
    logic [1:0]        state;
    logic              done;

    modport master (
        output start, stop, clear, dir, load_en, load_val, lap,
        input  count, lap_val, state, done
    );

    modport slave (
        input  start, stop, clear, dir, load_en, load_val, lap,
        output count, lap_val, state, done
    );
endinterface

// File: rtl/bcd_timer_n.sv
// N-digit BCD stopwatch/countdown timer with prescaled tick, preload, pause/resume,
// lap capture and selectable stop-or-wrap terminal behaviour.
module bcd_timer_n #(
    parameter int NDIG     = 3,
    parameter int PRESCALE = 1,
    parameter int WRAP     = 0
) (
    input logic         clk,
    input logic         ar,
    bcd_timer_n_if.slave bus
);
    localparam int W  = 4 * NDIG;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    count_q;
    logic [W-1:0]    lapVal_q;
    logic            done_q;
    logic [PW-1:0]   presc_q;

    logic [W-1:0]    stepVal;
    logic [W-1:0]    loadClamped;
    logic            carry;
    logic            allNine;
    logic            allZero;
    logic [3:0]      digit;
    logic [3:0]      loadDigit;
    logic            atTerminal;
    logic            tick;

    // One ripple pass gives the +/-1 result; a carry out of the top digit means we wrapped.
    always_comb begin
        stepVal     = count_q;
        loadClamped = '0;
        carry       = 1'b1;
        allNine     = 1'b1;
        allZero     = 1'b1;
        digit       = 4'd0;
        loadDigit   = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            digit   = count_q[4*i +: 4];
            allNine = allNine & (digit == 4'd9);
            allZero = allZero & (digit == 4'd0);
            if (carry) begin
                if (!bus.dir) begin
                    if (digit == 4'd9) begin
                        stepVal[4*i +: 4] = 4'd0;
                    end else begin
                        stepVal[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepVal[4*i +: 4] = 4'd9;
                    end else begin
                        stepVal[4*i +: 4] = digit - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
            loadDigit              = bus.load_val[4*i +: 4];
            loadClamped[4*i +: 4]  = (loadDigit > 4'd9) ? 4'd9 : loadDigit;
        end
    end

    assign atTerminal = bus.dir ? allZero : allNine;
    assign tick       = (state_q == RUN) && (presc_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (ar) begin
            state_q  <= IDLE;
            count_q  <= '0;
            lapVal_q <= '0;
            done_q   <= 1'b0;
            presc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.lap && ((state_q == RUN) || (state_q == PAUSE))) begin
                lapVal_q <= count_q;
            end
            case (state_q)
                IDLE: begin
                    presc_q <= '0;
                    if (bus.clear) begin
                        count_q <= '0;
                    end else if (bus.load_en) begin
                        count_q <= loadClamped;
                    end else if (bus.start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.clear) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        presc_q <= '0;
                    end else if (bus.stop) begin
                        state_q <= PAUSE;
                        presc_q <= '0;
                    end else if (tick) begin
                        presc_q <= '0;
                        done_q  <= atTerminal;
                        if (atTerminal && (WRAP == 0)) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= stepVal;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    presc_q <= '0;
                    if (bus.clear) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (bus.load_en) begin
                        count_q <= loadClamped;
                    end else if (bus.start) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    presc_q <= '0;
                    if (bus.clear) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (bus.load_en) begin
                        state_q <= IDLE;
                        count_q <= loadClamped;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.lap_val = lapVal_q;
    assign bus.state   = state_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_bcd_timer_n.sv
// Self-checking bench for bcd_timer_n: three instances cover stop-at-terminal,
// prescaled counting and wrap-around; expected outputs go through a scoreboard queue.
module tb_bcd_timer_n;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk = 1'b0;
    logic        ar  = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, dir = 1'b0;
    logic        loadEn = 1'b0, lap = 1'b0;
    logic [11:0] loadVal = 12'h000;
    int          sel = 0;
    logic [11:0] lapExp = 12'h000;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [11:0] count;
        logic [1:0]  state;
        logic        done;
        logic [11:0] lapVal;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    bcd_timer_n_if #(.NDIG(3)) ifA ();
    bcd_timer_n_if #(.NDIG(3)) ifB ();
    bcd_timer_n_if #(.NDIG(3)) ifC ();

    // Only the selected instance sees the action inputs; the others idle.
    assign ifA.start = start && (sel == 0);
    assign ifA.stop = stop && (sel == 0);
    assign ifA.clear = clear && (sel == 0);
    assign ifA.load_en = loadEn && (sel == 0);
    assign ifA.lap = lap && (sel == 0);
    assign ifA.dir = dir;
    assign ifA.load_val = loadVal;
    assign ifB.start = start && (sel == 1);
    assign ifB.stop = stop && (sel == 1);
    assign ifB.clear = clear && (sel == 1);
    assign ifB.load_en = loadEn && (sel == 1);
    assign ifB.lap = lap && (sel == 1);
    assign ifB.dir = dir;
    assign ifB.load_val = loadVal;
    assign ifC.start = start && (sel == 2);
    assign ifC.stop = stop && (sel == 2);
    assign ifC.clear = clear && (sel == 2);
    assign ifC.load_en = loadEn && (sel == 2);
    assign ifC.lap = lap && (sel == 2);
    assign ifC.dir = dir;
    assign ifC.load_val = loadVal;

    bcd_timer_n #(.NDIG(3), .PRESCALE(1), .WRAP(0)) dutA (.clk(clk), .ar(ar), .bus(ifA.slave));
    bcd_timer_n #(.NDIG(3), .PRESCALE(4), .WRAP(0)) dutB (.clk(clk), .ar(ar), .bus(ifB.slave));
    bcd_timer_n #(.NDIG(3), .PRESCALE(1), .WRAP(1)) dutC (.clk(clk), .ar(ar), .bus(ifC.slave));

    function automatic logic [11:0] toBcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Push the expectation for the next edge, clock, then pop it against the selected DUT.
    task automatic applyStimulus(input string tag, input logic [11:0] cnt, input logic [1:0] st, input logic dn);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.count = cnt;
        e.state = st;
        e.done = dn;
        e.lapVal = lapExp;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        case (sel)
            0: begin
                checkOutput({got.tag, ".count"}, 32'(ifA.count), 32'(got.count));
                checkOutput({got.tag, ".state"}, 32'(ifA.state), 32'(got.state));
                checkOutput({got.tag, ".done"}, 32'(ifA.done), 32'(got.done));
                checkOutput({got.tag, ".lap"}, 32'(ifA.lap_val), 32'(got.lapVal));
            end
            1: begin
                checkOutput({got.tag, ".count"}, 32'(ifB.count), 32'(got.count));
                checkOutput({got.tag, ".state"}, 32'(ifB.state), 32'(got.state));
                checkOutput({got.tag, ".done"}, 32'(ifB.done), 32'(got.done));
                checkOutput({got.tag, ".lap"}, 32'(ifB.lap_val), 32'(got.lapVal));
            end
            default: begin
                checkOutput({got.tag, ".count"}, 32'(ifC.count), 32'(got.count));
                checkOutput({got.tag, ".state"}, 32'(ifC.state), 32'(got.state));
                checkOutput({got.tag, ".done"}, 32'(ifC.done), 32'(got.done));
                checkOutput({got.tag, ".lap"}, 32'(ifC.lap_val), 32'(got.lapVal));
            end
        endcase
    endtask

    initial begin
        // Reset all three instances
        ar = 1'b1;
        sel = 0; applyStimulus("rstA", 12'h000, S_IDLE, 1'b0);
        sel = 1; applyStimulus("rstB", 12'h000, S_IDLE, 1'b0);
        sel = 2; applyStimulus("rstC", 12'h000, S_IDLE, 1'b0);
        ar = 1'b0;

        // Up count to terminal, stop in DONE
        sel = 0; dir = 1'b0;
        start = 1'b1; applyStimulus("upStart", 12'h000, S_RUN, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 999; k++) applyStimulus("up", toBcd(k), S_RUN, 1'b0);
        applyStimulus("upDone", 12'h999, S_DONE, 1'b1);
        applyStimulus("upHold", 12'h999, S_DONE, 1'b0);
        start = 1'b1; stop = 1'b1;
        applyStimulus("doneIgnore", 12'h999, S_DONE, 1'b0);
        start = 1'b0; stop = 1'b0;
        loadVal = 12'h123; loadEn = 1'b1;
        applyStimulus("doneLoad", 12'h123, S_IDLE, 1'b0);
        loadEn = 1'b0;
        clear = 1'b1; applyStimulus("upClear", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0;

        // Prescale 4, pause and resume
        sel = 1;
        start = 1'b1; applyStimulus("psStart", 12'h000, S_RUN, 1'b0);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            for (int j = 0; j < 3; j++) applyStimulus("psWait", toBcd(n - 1), S_RUN, 1'b0);
            applyStimulus("psTick", toBcd(n), S_RUN, 1'b0);
        end
        stop = 1'b1; applyStimulus("psStop", 12'h005, S_PAUSE, 1'b0);
        stop = 1'b0;
        for (int j = 0; j < 20; j++) applyStimulus("psHold", 12'h005, S_PAUSE, 1'b0);
        start = 1'b1; applyStimulus("psResume", 12'h005, S_RUN, 1'b0);
        start = 1'b0;
        for (int j = 0; j < 3; j++) applyStimulus("psWait2", 12'h005, S_RUN, 1'b0);
        applyStimulus("psTick6", 12'h006, S_RUN, 1'b0);
        clear = 1'b1; applyStimulus("psClear", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0;

        // Down count from 100 to DONE
        sel = 0;
        loadVal = 12'h100; loadEn = 1'b1;
        applyStimulus("dnLoad", 12'h100, S_IDLE, 1'b0);
        loadEn = 1'b0; dir = 1'b1;
        start = 1'b1; applyStimulus("dnStart", 12'h100, S_RUN, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 100; k++) applyStimulus("dn", toBcd(100 - k), S_RUN, 1'b0);
        applyStimulus("dnDone", 12'h000, S_DONE, 1'b1);
        clear = 1'b1; applyStimulus("dnClear", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0; dir = 1'b0;

        // Wrap instance rolls 999 -> 000 and keeps running
        sel = 2;
        loadVal = 12'h998; loadEn = 1'b1;
        applyStimulus("wrLoad", 12'h998, S_IDLE, 1'b0);
        loadEn = 1'b0;
        start = 1'b1; applyStimulus("wrStart", 12'h998, S_RUN, 1'b0);
        start = 1'b0;
        applyStimulus("wr999", 12'h999, S_RUN, 1'b0);
        applyStimulus("wrWrap", 12'h000, S_RUN, 1'b1);
        applyStimulus("wr001", 12'h001, S_RUN, 1'b0);
        clear = 1'b1; applyStimulus("wrClear", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0;

        // Input priority and load clamping
        sel = 0;
        start = 1'b1; applyStimulus("prStart", 12'h000, S_RUN, 1'b0);
        start = 1'b0; applyStimulus("prTick", 12'h001, S_RUN, 1'b0);
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        applyStimulus("prClrWins", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0; stop = 1'b0;
        applyStimulus("prRestart", 12'h000, S_RUN, 1'b0);
        start = 1'b0; applyStimulus("prTick2", 12'h001, S_RUN, 1'b0);
        stop = 1'b1; applyStimulus("prStop", 12'h001, S_PAUSE, 1'b0);
        stop = 1'b0;
        loadVal = 12'h250; loadEn = 1'b1; start = 1'b1;
        applyStimulus("prLoadWins", 12'h250, S_PAUSE, 1'b0);
        start = 1'b0; loadVal = 12'hA3F;
        applyStimulus("prClamp", 12'h939, S_PAUSE, 1'b0);
        loadEn = 1'b0;
        clear = 1'b1; applyStimulus("prClear", 12'h000, S_IDLE, 1'b0);
        clear = 1'b0;

        // Lap capture and mid-run reset
        loadVal = 12'h041; loadEn = 1'b1;
        applyStimulus("lpLoad", 12'h041, S_IDLE, 1'b0);
        loadEn = 1'b0;
        lap = 1'b1; applyStimulus("lpIdleIgn", 12'h041, S_IDLE, 1'b0);
        lap = 1'b0;
        start = 1'b1; applyStimulus("lpStart", 12'h041, S_RUN, 1'b0);
        start = 1'b0; applyStimulus("lp042", 12'h042, S_RUN, 1'b0);
        lap = 1'b1; lapExp = 12'h042;
        applyStimulus("lpCapture", 12'h043, S_RUN, 1'b0);
        lap = 1'b0; applyStimulus("lp044", 12'h044, S_RUN, 1'b0);
        ar = 1'b1; lapExp = 12'h000;
        applyStimulus("lpReset", 12'h000, S_IDLE, 1'b0);
        ar = 1'b0; applyStimulus("lpIdle", 12'h000, S_IDLE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bcd_timer_n.md
Name: bcd_timer_n

Overview:
- Parametrised N-digit BCD stopwatch/countdown timer with a run-control state machine.
- Next generation of the 3-digit up-only BCD counter: adds digit-count generality, a tick prescaler, up/down counting, preload, pause/resume, lap capture, and a selectable terminal behaviour (stop or wrap).
- Feeds display/BCD-to-7-segment logic; control inputs come from debounced buttons.

Parameters:
NDIG, 3, number of BCD digits (1..8); digit 0 is least significant
PRESCALE, 1, clk cycles per count tick (>=1); 1 = count every cycle in RUN
WRAP, 0, 0 = stop in DONE at terminal value; 1 = wrap and keep running

Ports:
clk  in  1  system clock, all logic on rising edge
ar  in  1  reset, synchronous, active-high
start  in  1  level; begin/resume counting
stop  in  1  level; pause counting
clear  in  1  level; zero count, return to IDLE
dir  in  1  0 = count up, 1 = count down
load_en  in  1  preload count from load_val
load_val  in  4*NDIG  preload value, packed BCD
lap  in  1  capture current count into lap_val
count  out  4*NDIG  current count, packed BCD, registered
lap_val  out  4*NDIG  last captured count, registered
state  out  2  FSM state encoding
done  out  1  one-cycle pulse on terminal tick

Behaviour:
- Reset (ar=1 at clk edge): state=IDLE, count=0, lap_val=0, done=0, prescaler=0. Reset mid-count overrides all inputs.
- State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
- Input priority per cycle: clear > load_en > stop > start.
- IDLE: clear -> count=0, stay IDLE; load_en -> count=load_val, stay IDLE; start -> RUN, count unchanged.
- RUN: clear -> IDLE, count=0; load_en ignored; stop -> PAUSE, no count update that cycle; else count on tick.
- PAUSE: clear -> IDLE, count=0; load_en -> count=load_val, stay PAUSE; start -> RUN; count frozen.
- DONE: clear -> IDLE, count=0; load_en -> IDLE, count=load_val; start and stop ignored.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN; tick asserted in the cycle it equals PRESCALE-1, then it returns to 0.
  - Held at 0 outside RUN, so the first tick after entering RUN occurs PRESCALE cycles later.
- Tick arithmetic:
  - Up: digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit.
  - Down: digit 0 decrements; a digit at 0 rolls to 9 and borrows from the next digit.
  - Carry/borrow chain is combinational across all NDIG digits; single-cycle update.
- dir is sampled at each tick; a change takes effect on the next tick.
- Terminal value: all digits 9 (up) or all digits 0 (down).
  - On a tick with count at terminal and WRAP=0: count unchanged, state->DONE, done=1 for that one cycle.
  - On a tick with count at terminal and WRAP=1: count becomes all 0 (up) or all 9 (down), state stays RUN, done=1 for one cycle.
- load_val digits >9 are clamped to 9 per digit on load.
- lap:
  - In RUN or PAUSE, lap=1 sets lap_val to the count value present before that edge's update.
  - Ignored in IDLE and DONE.
  - lap_val is cleared only by reset.
- done is 0 in every cycle other than a terminal tick.

Test Plan:
- NDIG=3, PRESCALE=1, WRAP=0: reset, start for 1 cycle, dir=0 -> count 000,001,...; after 999 ticks count=999; next tick state=DONE, done pulses once, count holds 999.
- PRESCALE=4: start -> first increment 4 cycles after entering RUN, then every 4 cycles; stop at count=005 -> PAUSE, count holds for 20 cycles; start -> resumes 006 after 4 cycles.
- Down count: in IDLE, load_val=12'h100, load_en -> count=100; start, dir=1 -> 099, 098, ...; reaches 000 after 100 ticks; next tick -> DONE, done=1.
- WRAP=1, dir=0: load 998, run -> 999, 000 with done=1 on the wrap tick, state stays RUN.
- Priority: in RUN, assert clear+stop+start same cycle -> IDLE, count=000. In PAUSE, assert load_en+start -> count=load_val, state PAUSE. load_val=12'hA3F -> count=939.
- Lap and reset: running at 042, pulse lap -> lap_val=042 while count=043; ar=1 mid-run -> next edge count=000, lap_val=000, state=IDLE, done=0.
